// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared encodings for the UART parity unit: parity-type codes
//            carried on PAR_TYP and the RX checker state encoding.
// Contents : PAR_EVEN / PAR_ODD / PAR_MARK / PAR_SPACE, rx_state_t
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   // Parity-type codes as they appear on PAR_TYP
   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_MARK  = 2'b10;
   localparam logic [1:0] PAR_SPACE = 2'b11;

   // RX checker states
   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_REPORT = 2'd3
   } rx_state_t;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/parity_bit_sel.sv
// ============================================================================
// Module   : parity_bit_sel
// Purpose  : Combinational parity-bit rule shared by the TX generator and the
//            RX checker so both sides always agree on the expected bit.
// Ports    : i_xor    - XOR reduction of the data word
//            i_enable - parity enabled; 0 forces the output low
//            i_type   - parity type code (even/odd/mark/space)
//            o_bit    - resulting parity bit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_bit_sel
   import uart_pkg::*;
(
   input  logic       i_xor,
   input  logic       i_enable,
   input  logic [1:0] i_type,
   output logic       o_bit
);

   always_comb begin
      o_bit = 1'b0;
      if (i_enable) begin
         case (i_type)
            PAR_EVEN:  o_bit = i_xor;
            PAR_ODD:   o_bit = ~i_xor;
            PAR_MARK:  o_bit = 1'b1;
            PAR_SPACE: o_bit = 1'b0;
            default:   o_bit = 1'b0;
         endcase
      end
   end

endmodule : parity_bit_sel

`default_nettype wire

// File: rtl/uart_parity_unit.sv
// ============================================================================
// Module   : uart_parity_unit
// Purpose  : Parity generator (TX) and checker (RX) for the UART datapath.
//            TX latches a word plus parity mode while the serializer is idle
//            and presents a stable registered parity bit for the frame.
//            RX accumulates sampled data bits, checks the received parity
//            bit and emits a one-cycle completion/error report.
// Ports    : CLK, RST            - clock, synchronous active-high reset
//            PAR_EN, PAR_TYP     - parity enable and type (shared TX/RX mode)
//            P_DATA, tx_load,
//            busy                - TX word, capture request, serializer busy
//            par_bit             - registered TX parity bit
//            rx_start,
//            rx_bit_valid, rx_bit- RX frame start, bit strobe, sampled bit
//            chk_done, par_err   - RX report pulse and mismatch flag
//            rx_busy             - checker inside a frame
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_parity_unit
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_TYP,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  tx_load,
   input  logic                  busy,
   output logic                  par_bit,
   input  logic                  rx_start,
   input  logic                  rx_bit_valid,
   input  logic                  rx_bit,
   output logic                  chk_done,
   output logic                  par_err,
   output logic                  rx_busy
);

   localparam int              CNT_W  = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_WIDTH - 1);

   // ------------------------------------------------------------------------
   // TX half
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_tx_word;
   logic                  r_tx_en;
   logic [1:0]            r_tx_typ;
   logic                  r_par_bit;
   logic                  w_tx_exp;

   parity_bit_sel u_tx_sel (
      .i_xor    (^r_tx_word),
      .i_enable (r_tx_en),
      .i_type   (r_tx_typ),
      .o_bit    (w_tx_exp)
   );

   // par_bit is computed from the captured copy, so it lags a capture by
   // one cycle and is immune to PAR_* activity between captures.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_tx_word <= '0;
         r_tx_en   <= 1'b1;
         r_tx_typ  <= PAR_EVEN;
         r_par_bit <= 1'b0;
      end else begin
         if (tx_load && !busy) begin
            r_tx_word <= P_DATA;
            r_tx_en   <= PAR_EN;
            r_tx_typ  <= PAR_TYP;
         end
         r_par_bit <= w_tx_exp;
      end
   end

   assign par_bit = r_par_bit;

   // ------------------------------------------------------------------------
   // RX half
   // ------------------------------------------------------------------------
   rx_state_t        r_state,  w_state_nxt;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
   logic             r_acc,    w_acc_nxt;
   logic             r_mis,    w_mis_nxt;
   logic             r_rx_en,  w_en_nxt;
   logic [1:0]       r_rx_typ, w_typ_nxt;
   logic             w_rx_exp;

   // The accumulator is complete by the time PARITY is reached, so the
   // expected bit can be taken straight from it.
   parity_bit_sel u_rx_sel (
      .i_xor    (r_acc),
      .i_enable (r_rx_en),
      .i_type   (r_rx_typ),
      .o_bit    (w_rx_exp)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= RX_IDLE;
         r_cnt    <= '0;
         r_acc    <= 1'b0;
         r_mis    <= 1'b0;
         r_rx_en  <= 1'b1;
         r_rx_typ <= PAR_EVEN;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_acc    <= w_acc_nxt;
         r_mis    <= w_mis_nxt;
         r_rx_en  <= w_en_nxt;
         r_rx_typ <= w_typ_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      w_mis_nxt   = r_mis;
      w_en_nxt    = r_rx_en;
      w_typ_nxt   = r_rx_typ;

      // A start request opens a fresh frame from any state. In REPORT the
      // outputs decode the current state, so the pending report still
      // appears for its cycle before the new frame begins in DATA.
      if (rx_start) begin
         w_state_nxt = RX_DATA;
         w_cnt_nxt   = '0;
         w_acc_nxt   = 1'b0;
         w_mis_nxt   = 1'b0;
         w_en_nxt    = PAR_EN;
         w_typ_nxt   = PAR_TYP;
      end else begin
         case (r_state)
            RX_IDLE: begin
               w_state_nxt = RX_IDLE;
            end
            RX_DATA: begin
               if (rx_bit_valid) begin
                  w_acc_nxt = r_acc ^ rx_bit;
                  w_cnt_nxt = r_cnt + CNT_W'(1);
                  if (r_cnt == c_LAST) begin
                     w_state_nxt = r_rx_en ? RX_PARITY : RX_REPORT;
                  end
               end
            end
            RX_PARITY: begin
               if (rx_bit_valid) begin
                  w_mis_nxt   = (rx_bit != w_rx_exp);
                  w_state_nxt = RX_REPORT;
               end
            end
            RX_REPORT: begin
               w_state_nxt = RX_IDLE;
            end
            default: begin
               w_state_nxt = RX_IDLE;
            end
         endcase
      end
   end

   // r_mis is cleared on every frame open, so it is always 0 when parity
   // is disabled.
   assign chk_done = (r_state == RX_REPORT);
   assign par_err  = (r_state == RX_REPORT) && r_mis;
   assign rx_busy  = (r_state != RX_IDLE);

endmodule : uart_parity_unit

`default_nettype wire

// File: doc/uart_parity_unit.md
Name: uart_parity_unit

Overview:
Parametrised parity generator and checker for the UART datapath. The TX half captures a parallel word while the transmitter is idle and drives a stable parity bit for the whole frame. The RX half accumulates serial data bits as they are sampled, compares the received parity bit and reports errors. The block sits between the UART FSMs (TX serializer, RX sampler) and the host data registers.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; legal range 5..16.
CNT_W, $clog2(DATA_WIDTH+1), RX bit-counter width; derived, not overridden.

Ports:
CLK  in  1  block clock
RST  in  1  reset; synchronous, active-high
PAR_EN  in  1  parity enable; 0 = no parity bit in frame
PAR_TYP  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
P_DATA  in  DATA_WIDTH  TX parallel word
tx_load  in  1  capture request from TX FSM
busy  in  1  TX serializer active
par_bit  out  1  TX parity bit, registered
rx_start  in  1  start bit detected; opens an RX frame
rx_bit_valid  in  1  one-cycle strobe: rx_bit holds a sampled bit
rx_bit  in  1  sampled serial bit, LSB first
chk_done  out  1  one-cycle pulse: RX frame check complete
par_err  out  1  valid with chk_done; 1 = parity mismatch
rx_busy  out  1  checker inside a frame

Behaviour:
- Reset (RST=1 at a CLK edge): captured word = 0, captured mode = even/enabled, par_bit = 0, checker state = IDLE, counter = 0, accumulator = 0, chk_done = 0, par_err = 0, rx_busy = 0. Reset mid-frame aborts the frame with no chk_done.
- TX capture: on tx_load=1 && busy=0, latch P_DATA, PAR_EN and PAR_TYP. tx_load while busy=1 is ignored. par_bit updates one cycle after capture and holds until the next capture.
- par_bit values: captured PAR_EN=0 -> 0; even -> XOR of captured word; odd -> inverted XOR; mark -> 1; space -> 0. Changes on the PAR_* inputs without a capture do not affect par_bit.
- RX FSM states: IDLE, DATA, PARITY, REPORT.
- IDLE: on rx_start, latch PAR_EN/PAR_TYP, clear counter and accumulator, go to DATA. rx_busy=1 in every state except IDLE.
- DATA: each rx_bit_valid XORs rx_bit into the accumulator and increments the counter. When the DATA_WIDTH-th bit is taken, go to PARITY if the latched enable is set, else REPORT.
- PARITY: on rx_bit_valid, compute the expected bit per the latched mode using the same rule as TX. Set mismatch = rx_bit != expected. Go to REPORT.
- REPORT: chk_done=1 and par_err=mismatch for exactly one cycle, then go to IDLE. With parity disabled, par_err=0.
- chk_done and par_err are 0 outside REPORT.
- rx_start while in DATA or PARITY: restarts the frame the same way as from IDLE. No chk_done is issued for the abandoned frame.
- rx_start in REPORT: the report completes, then the FSM goes directly to DATA with a fresh frame and does not pass through IDLE.
- rx_start and rx_bit_valid in the same cycle: rx_start wins and the bit is discarded.
- rx_bit_valid in IDLE or REPORT is ignored.
- The counter never exceeds DATA_WIDTH and does not wrap.
- TX and RX halves are fully independent and may operate in the same cycle.

Decomposition:
- Package uart_pkg holds the PAR_TYP encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE) and the RX state encoding.
- One natural sub-module: parity_bit_sel. It is combinational, takes (xor_in, enable, type) and returns the expected bit. It is instantiated by both the TX and RX halves so the two use identical rules.

Test Plan:
- Reset, DATA_WIDTH=8: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=00, tx_load=1, busy=0 -> par_bit=0 next cycle. Then PAR_TYP=01 with a new load -> par_bit=1.
- Busy blocking: busy=1, tx_load=1, P_DATA=8'h01 -> par_bit stays at its previous value. Drop busy and load -> par_bit=1 (even).
- Mark/space: PAR_TYP=10 loaded with any data -> par_bit=1. PAR_TYP=11 -> 0. PAR_EN=0 -> 0.
- RX good frame: rx_start, then 8'h3C LSB first, then parity bit 0 (even) -> chk_done pulse one cycle after the parity strobe, par_err=0. Same frame with parity bit 1 -> par_err=1.
- RX restart: rx_start, 4 data bits, rx_start again, then a full good frame -> exactly one chk_done, par_err=0. Counter equals 0 after the second rx_start.
- RX no parity / reset abort: PAR_EN=0, 8 bits -> chk_done after the 8th strobe, par_err=0. Separately, RST asserted mid-DATA -> rx_busy=0 next cycle and no chk_done.
